// File: rtl/dot_pkg.sv
// Shared width helpers, default configuration and pipeline stage control type
// for the dot_int_pipe_acc signed dot-product accumulator.
package dot_pkg;

  localparam int DOT_BIT_WIDTH  = 8;
  localparam int DOT_K          = 32;
  localparam int DOT_MAX_BLOCKS = 8;

  function automatic int prd_w(input int bit_width);
    return 2 * bit_width;
  endfunction

  function automatic int sum_w(input int bit_width, input int k);
    return prd_w(bit_width) + $clog2(k);
  endfunction

  function automatic int out_w(input int bit_width, input int k, input int max_blocks);
    return sum_w(bit_width, k) + $clog2(max_blocks);
  endfunction

  // A single-block configuration still needs a one-bit counter to exist.
  function automatic int cnt_w(input int max_blocks);
    return (max_blocks > 1) ? $clog2(max_blocks) : 1;
  endfunction

  localparam int DOT_CNT_W = cnt_w(DOT_MAX_BLOCKS);

  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;

endpackage

// File: rtl/vec_sum_int.sv
// Combinational signed adder tree: sums N signed IN_W-bit values (N a power
// of two) into an IN_W+$clog2(N)-bit result with no possibility of overflow.
module vec_sum_int #(
  parameter  int IN_W  = 16,
  parameter  int N     = 32,
  localparam int OUT_W = IN_W + $clog2(N)
) (
  input  logic [N-1:0][IN_W-1:0] i_vec,
  output logic signed [OUT_W-1:0] o_sum
);

  // Heap layout: leaves at N-1 .. 2N-2, node j sums children 2j+1 and 2j+2.
  logic signed [OUT_W-1:0] node [2*N-1];

  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no path can leave it unassigned and infer a latch.
    node = '{default: '0};
    for (int i = 0; i < N; i++) begin
      node[N-1+i] = OUT_W'($signed(i_vec[i]));
    end
    for (int i = N - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    o_sum = node[0];
  end

endmodule

// File: rtl/dot_int_pipe_acc.sv
// Pipelined signed dot product with multi-beat accumulation and a global stall.
// Define DOT_IN_REG_EN to add an S0 input register (latency 3 -> 4 cycles).
module dot_int_pipe_acc
  import dot_pkg::*;
#(
  parameter  int BIT_WIDTH  = DOT_BIT_WIDTH,
  parameter  int K          = DOT_K,
  parameter  int MAX_BLOCKS = DOT_MAX_BLOCKS,
  localparam int PRD_W      = prd_w(BIT_WIDTH),
  localparam int SUM_W      = sum_w(BIT_WIDTH, K),
  localparam int OUT_W      = out_w(BIT_WIDTH, K, MAX_BLOCKS),
  localparam int CNT_W      = cnt_w(MAX_BLOCKS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [K-1:0][BIT_WIDTH-1:0]   i_vec_a,
  input  logic [K-1:0][BIT_WIDTH-1:0]   i_vec_b,
  input  logic                          i_valid,
  input  logic                          i_last,
  output logic                          o_ready,
  output logic signed [OUT_W-1:0]       o_dp,
  output logic                          o_valid,
  output logic                          o_trunc,
  input  logic                          i_ready
);

  typedef struct packed {
    stage_ctl_t                   ctl;
    logic [K-1:0][PRD_W-1:0]      prod;
  } s1_t;

  typedef struct packed {
    stage_ctl_t                   ctl;
    logic signed [SUM_W-1:0]      sum;
  } s2_t;

  logic                           en;
  logic [K-1:0][BIT_WIDTH-1:0]    feed_a, feed_b;
  stage_ctl_t                     feed_ctl;
  s1_t                            s1_q, s1_d;
  s2_t                            s2_q, s2_d;
  logic signed [SUM_W-1:0]        tree_sum;

  logic signed [OUT_W-1:0]        acc_q, acc_d, acc_new, sum_ext;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           first_q, first_d;
  logic signed [OUT_W-1:0]        o_dp_q, o_dp_d;
  logic                           o_valid_q, o_valid_d;
  logic                           o_trunc_q, o_trunc_d;
  logic                           close;

  // The whole pipeline freezes while a result is held for a stalled consumer.
  assign en = !o_valid_q || i_ready;

`ifdef DOT_IN_REG_EN
  logic [K-1:0][BIT_WIDTH-1:0]    s0_a_q, s0_b_q;
  stage_ctl_t                     s0_ctl_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_a_q   <= '0;
      s0_b_q   <= '0;
      s0_ctl_q <= '0;
    end else if (en) begin
      s0_a_q   <= i_vec_a;
      s0_b_q   <= i_vec_b;
      s0_ctl_q <= '{valid: i_valid, last: i_last};
    end
  end

  assign feed_a   = s0_a_q;
  assign feed_b   = s0_b_q;
  assign feed_ctl = s0_ctl_q;
`else
  assign feed_a   = i_vec_a;
  assign feed_b   = i_vec_b;
  assign feed_ctl = '{valid: i_valid, last: i_last};
`endif

  always_comb begin
    s1_d.ctl = feed_ctl;
    for (int i = 0; i < K; i++) begin
      s1_d.prod[i] = PRD_W'($signed(feed_a[i])) * PRD_W'($signed(feed_b[i]));
    end
  end

  vec_sum_int #(
    .IN_W (PRD_W),
    .N    (K)
  ) u_vec_sum (
    .i_vec (s1_q.prod),
    .o_sum (tree_sum)
  );

  assign s2_d.ctl = s1_q.ctl;
  assign s2_d.sum = tree_sum;

  assign sum_ext = OUT_W'($signed(s2_q.sum));
  assign acc_new = (first_q ? '0 : acc_q) + sum_ext;
  assign close   = s2_q.ctl.last || (cnt_q == CNT_W'(MAX_BLOCKS - 1));

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    o_dp_d    = o_dp_q;
    o_valid_d = o_valid_q;
    o_trunc_d = o_trunc_q;
    if (en) begin
      if (s2_q.ctl.valid) begin
        if (close) begin
          o_dp_d    = acc_new;
          o_valid_d = 1'b1;
          o_trunc_d = !s2_q.ctl.last;
          cnt_d     = '0;
          first_d   = 1'b1;
        end else begin
          acc_d     = acc_new;
          cnt_d     = cnt_q + CNT_W'(1);
          first_d   = 1'b0;
        end
      end
      // A fresh close in the same cycle as i_ready reloads instead of clearing.
      if (!(s2_q.ctl.valid && close)) begin
        o_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the product and sum registers are plain flops, not a RAM, so they are reset with everything else to keep o_dp and the pipeline deterministic.
      s1_q      <= '0;
      s2_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      o_dp_q    <= '0;
      o_valid_q <= 1'b0;
      o_trunc_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (en) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      o_dp_q    <= o_dp_d;
      o_valid_q <= o_valid_d;
      o_trunc_q <= o_trunc_d;
    end
  end

  assign o_ready = en;
  assign o_dp    = o_dp_q;
  assign o_valid = o_valid_q;
  assign o_trunc = o_trunc_q;

endmodule

// File: tb/tb_dot_int_pipe_acc.sv
// Scoreboard bench for dot_int_pipe_acc: a group-level reference model queues
// expected results on each accepted beat; a monitor pops them on each handshake.
module tb_dot_int_pipe_acc;
  import dot_pkg::*;

  localparam int BW    = DOT_BIT_WIDTH;
  localparam int K     = DOT_K;
  localparam int MB    = DOT_MAX_BLOCKS;
  localparam int OUT_W = out_w(BW, K, MB);
`ifdef DOT_IN_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef logic [K-1:0][BW-1:0] vec_t;
  typedef struct {
    int dp;
    bit trunc;
  } exp_t;

  logic                     i_clk   = 1'b0;
  logic                     i_rst_n = 1'b0;
  vec_t                     i_vec_a = '0;
  vec_t                     i_vec_b = '0;
  logic                     i_valid = 1'b0;
  logic                     i_last  = 1'b0;
  logic                     i_ready = 1'b1;
  logic                     o_ready;
  logic signed [OUT_W-1:0]  o_dp;
  logic                     o_valid;
  logic                     o_trunc;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   acc_m = 0;
  int   cnt_m = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  bit   bp_done = 1'b0;

  always #5 i_clk = ~i_clk;

  dot_int_pipe_acc dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vec_a (i_vec_a),
    .i_vec_b (i_vec_b),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_dp    (o_dp),
    .o_valid (o_valid),
    .o_trunc (o_trunc),
    .i_ready (i_ready)
  );

  task automatic check(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Group-level model: plain integer dot product, closing on last or on the limit.
  function automatic void model_accept(input vec_t a, input vec_t b, input bit last);
    int dot = 0;
    for (int i = 0; i < K; i++) begin
      dot += int'($signed(a[i])) * int'($signed(b[i]));
    end
    acc_m += dot;
    cnt_m++;
    if (last || cnt_m == MB) begin
      exp_q.push_back('{dp: acc_m, trunc: !last});
      acc_m = 0;
      cnt_m = 0;
    end
  endfunction

  function automatic vec_t rv();
    vec_t v;
    for (int i = 0; i < K; i++) v[i] = BW'($urandom);
    return v;
  endfunction

  function automatic vec_t fill(input int val);
    vec_t v;
    for (int i = 0; i < K; i++) v[i] = BW'(val);
    return v;
  endfunction

  task automatic drive_beat(input vec_t a, input vec_t b, input bit last);
    int n = 0;
    @(negedge i_clk);
    i_vec_a = a;
    i_vec_b = b;
    i_last  = last;
    i_valid = 1'b1;
    #1;
    while (!o_ready && n < 500) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: o_ready stayed 0 for %0d cycles", n);
    end else begin
      model_accept(a, b, last);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    #3;
    i_rst_n = 1'b0;
    exp_q.delete();
    acc_m = 0;
    cnt_m = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    #2;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_dp", o_dp, 0);
    check("rst_o_trunc", o_trunc, 0);
    check("rst_o_ready", o_ready, 1);
  endtask

  task automatic wait_result();
    int n = 0;
    do begin
      @(negedge i_clk);
      #2;
      n++;
    end while (!o_valid && n < 100);
    check("result_timeout", o_valid, 1);
  endtask

  task automatic latency_check(input int exp_dp, input bit exp_tr);
    for (int n = 1; n <= LAT; n++) begin
      @(negedge i_clk);
      #2;
      check("latency_valid", o_valid, (n == LAT));
    end
    check("latency_dp", o_dp, exp_dp);
    check("latency_trunc", o_trunc, exp_tr);
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      case (ready_mode)
        0:       i_ready = 1'b1;
        2:       i_ready = 1'b0;
        default: i_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rst_n && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got o_dp=%0d with no result expected at %0t", o_dp, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_dp", o_dp, e.dp);
          check("sb_trunc", o_trunc, e.trunc);
        end
      end
    end
  end

  initial begin : main
    int   n;
    int   vcnt;
    int   dp_seen;
    logic signed [OUT_W-1:0] held_dp;
    vec_t va;

    apply_reset();

    // Single beat: 32 * (3 * -2) = -192
    ready_mode = 0;
    drive_beat(fill(3), fill(-2), 1'b1);
    latency_check(-192, 1'b0);

    // Four-beat group, a[i]=i, b[i]=1: 4 * 496 = 1984, valid for exactly one cycle
    for (int i = 0; i < K; i++) va[i] = BW'(i);
    for (int bt = 0; bt < 4; bt++) drive_beat(va, fill(1), (bt == 3));
    vcnt = 0;
    dp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      #2;
      if (o_valid) begin
        vcnt++;
        dp_seen = int'(o_dp);
      end
    end
    check("grp4_valid_cycles", vcnt, 1);
    check("grp4_dp", dp_seen, 1984);

    // Extreme operands, group closed by the block limit
    for (int bt = 0; bt < MB; bt++) drive_beat(fill(-128), fill(-128), 1'b0);
    wait_result();
    check("extreme_dp", o_dp, 4194304);
    check("extreme_trunc", o_trunc, 1);

    // Backpressure: stall with a result pending while beats keep coming
    ready_mode = 2;
    bp_done = 1'b0;
    fork
      begin
        drive_beat(rv(), rv(), 1'b1);
        drive_beat(rv(), rv(), 1'b1);
        drive_beat(rv(), rv(), 1'b0);
        drive_beat(rv(), rv(), 1'b1);
        bp_done = 1'b1;
      end
    join_none
    wait_result();
    held_dp = o_dp;
    repeat (5) begin
      @(negedge i_clk);
      #2;
      check("bp_o_ready", o_ready, 0);
      check("bp_o_valid_hold", o_valid, 1);
      check("bp_o_dp_hold", o_dp, held_dp);
    end
    ready_mode = 1;
    n = 0;
    while (!bp_done && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    check("bp_resume", bp_done, 1);

    // Reset mid-group: partial sum discarded, fresh a=b=1 beat gives 32
    ready_mode = 0;
    repeat (10) @(negedge i_clk);
    drive_beat(rv(), rv(), 1'b0);
    drive_beat(rv(), rv(), 1'b0);
    apply_reset();
    drive_beat(fill(1), fill(1), 1'b1);
    latency_check(32, 1'b0);

    // Randomised groups of 1..11 beats with bubbles and random backpressure
    ready_mode = 1;
    for (int g = 0; g < 60; g++) begin
      int len = $urandom_range(1, 11);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 4) == 0) @(negedge i_clk);
        drive_beat(rv(), rv(), (j == len - 1));
      end
    end

    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (5) @(negedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_int_pipe_acc.md
Name: dot_int_pipe_acc

Overview:
- Pipelined signed-integer dot product with a valid/ready handshake and multi-block accumulation.
- Each accepted beat supplies two k-element vectors. Products are summed per beat, and beats are accumulated until a beat flagged last, or until the block limit is reached. One result is then emitted.
- Sits between operand buffers and the MX scaling/normalisation stage.
- Lets dot products longer than k run on a fixed-width datapath.

Parameters:
- bit_width, 8, element width (signed two's complement).
- k, 32, elements per beat; power of two, ≥2.
- max_blocks, 8, maximum beats per accumulation group; power of two, ≥1.
- prd_width, 2*bit_width, product width.
- sum_width, prd_width+$clog2(k), per-beat sum width.
- out_width, sum_width+$clog2(max_blocks), accumulator and result width. No overflow is possible.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset, asynchronous, active-low.
- i_vec_a, in, bit_width x k, signed operand A.
- i_vec_b, in, bit_width x k, signed operand B.
- i_valid, in, 1, input beat valid.
- i_last, in, 1, beat closes the current accumulation group.
- o_ready, out, 1, block can accept a beat.
- o_dp, out, out_width, signed accumulated dot product.
- o_valid, out, 1, o_dp valid.
- o_trunc, out, 1, group was closed by the block limit, not by i_last; qualified by o_valid.
- i_ready, in, 1, downstream accepts the result.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n; all state clears immediately on assertion.
- Reset values: o_valid=0, o_dp=0, o_trunc=0, all stage valid bits 0, accumulator 0, block counter 0, first-flag 1. o_ready=1 once reset is released.
- Global advance: en = !o_valid | i_ready. o_ready = en. All stages advance only when en=1; when en=0 every register holds.
- A beat is accepted when i_valid & o_ready.
- S1: register the k products a[i]*b[i], each sign-extended to prd_width. Register the S1 valid bit and last bit.
- S2: register the signed sum of the S1 products (sum_width) with its valid and last bits.
- S3, when S2 valid & en:
  - acc_new = (first ? 0 : acc) + sext(sum2).
  - close = last2 | (cnt == max_blocks-1).
  - If close: o_dp <= acc_new; o_valid <= 1; o_trunc <= !last2; cnt <= 0; first <= 1.
  - Else: acc <= acc_new; cnt++; first <= 0.
- Output: o_valid clears on i_ready when no new close occurs in the same cycle. A close and an i_ready in the same cycle reload o_dp/o_valid (back-to-back results).
- Latency: beat accepted at cycle t → S1 at t+1, S2 at t+2. For a closing beat, o_valid=1 at t+3 when unstalled.
- Throughput: one beat per cycle with no stalls; a one-beat group yields one result per cycle.
- Bubbles (i_valid=0) do not disturb the accumulator or counter.
- max_blocks=1: every beat closes a group; o_trunc = !i_last of that beat.
- Reset mid-group: partial accumulation is discarded and no result is produced.
- Arithmetic: all signed. Extreme case: k·max_blocks products of (-2^(bw-1))² fit exactly in out_width.

Optional Feature:
- Macro: DOT_IN_REG_EN.
- When defined: an S0 register captures i_vec_a, i_vec_b, i_valid and i_last on acceptance, gated by en. Latency becomes 4 cycles; o_ready is unchanged (= en).
- When undefined: operands feed S1 directly and latency is 3 cycles.
- Functional results are identical either way.

Decomposition:
- Package dot_pkg holds:
  - width helper functions (prd/sum/out width from bit_width, k, max_blocks);
  - the per-beat pipeline stage struct type (valid, last, payload), parametrised by width through the helpers;
  - localparam counter width $clog2(max_blocks), minimum 1.
- Natural sub-module: vec_sum_int, a combinational signed adder tree parametrised by width and length. It is instantiated once, between S1 and S2.

Test Plan:
- Single beat, k=32, a[i]=3, b[i]=-2, i_last=1 → after 3 cycles o_dp=-192, o_trunc=0.
- Group of 4 beats, a[i]=i, b[i]=1, last on beat 4 → one result, o_dp=4*496=1984, o_valid high for exactly 1 cycle when i_ready=1.
- Extreme values: max_blocks=8, all a=b=-128, 8 beats with no i_last → o_dp=8*32*16384=4194304, o_trunc=1.
- Backpressure: hold i_ready=0 with a result pending while beats stream → o_ready=0, no register changes, o_dp stable. Release → streaming resumes with no lost or duplicated beats.
- Reset pulse after 2 of 3 beats, then a fresh 1-beat group with a=b=1 → o_dp=32. No stale result appears.
- Build with DOT_IN_REG_EN and rerun the single-beat test → o_dp=-192 at 4 cycles.
